sys_ctrl: RTL and testbench

Command sequencer between the UART receiver and the register file, ALU and transmit path of the multi-clock system. It runs in the reference clock domain and decodes the byte stream from the RX side into four commands: 0xAA write, 0xBB read, 0xCC ALU-with-operands and 0xDD ALU-without-operands. It drives register-file and ALU strobes, enables the ALU clock gate only while an ALU operation is in flight, and pushes response bytes into the TX async FIFO.

---
 rtl/sys_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sys_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes the RX byte stream into register-file writes/reads
// and ALU operations, and queues response bytes toward the TX FIFO.
module sys_ctrl #(
  parameter int WIDTH_REG = 8,
  parameter int ADDR      = 4,
  parameter int fun       = 4
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic [WIDTH_REG-1:0]   i_RX_DATA,
  input  logic                   i_RX_VALID,
  input  logic                   i_RX_ERR,
  output logic [ADDR-1:0]        o_ADDR,
  output logic                   o_WR_EN,
  output logic [WIDTH_REG-1:0]   o_WR_DATA,
  output logic                   o_RD_EN,
  input  logic [WIDTH_REG-1:0]   i_RD_DATA,
  input  logic                   i_RD_VALID,
  output logic                   o_ALU_EN,
  output logic [fun-1:0]         o_ALU_FUN,
  input  logic [2*WIDTH_REG-1:0] i_ALU_OUT,
  input  logic                   i_ALU_VALID,
  output logic                   o_CLK_GATE_EN,
  output logic [WIDTH_REG-1:0]   o_TX_DATA,
  output logic                   o_TX_VALID,
  input  logic                   i_FIFO_FULL,
  output logic                   o_CMD_DROP
);

  localparam logic [WIDTH_REG-1:0] CMD_WR     = WIDTH_REG'(8'hAA);
  localparam logic [WIDTH_REG-1:0] CMD_RD     = WIDTH_REG'(8'hBB);
  localparam logic [WIDTH_REG-1:0] CMD_ALU_OP = WIDTH_REG'(8'hCC);
  localparam logic [WIDTH_REG-1:0] CMD_ALU    = WIDTH_REG'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB,
    ALU_FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t state, next_state;

  logic                 rx_ok, rx_bad, busy;
  logic [ADDR-1:0]      addr_d;
  logic                 wr_en_d, rd_en_d, alu_en_d, gate_d, tx_valid_d, drop_d;
  logic [WIDTH_REG-1:0] wr_data_d, tx_data_d, hi_d, hi_q;
  logic [fun-1:0]       alu_fun_d;
  logic                 two_d, two_q;

  assign rx_ok  = i_RX_VALID & ~i_RX_ERR;
  assign rx_bad = i_RX_VALID &  i_RX_ERR;
  assign busy   = (state == RD_WAIT) || (state == ALU_WAIT) ||
                  (state == TX_LO)   || (state == TX_HI);

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state         <= IDLE;
      o_ADDR        <= '0;
      o_WR_EN       <= 1'b0;
      o_WR_DATA     <= '0;
      o_RD_EN       <= 1'b0;
      o_ALU_EN      <= 1'b0;
      o_ALU_FUN     <= '0;
      o_CLK_GATE_EN <= 1'b0;
      o_TX_DATA     <= '0;
      o_TX_VALID    <= 1'b0;
      o_CMD_DROP    <= 1'b0;
      hi_q          <= '0;
      two_q         <= 1'b0;
    end else begin
      state         <= next_state;
      o_ADDR        <= addr_d;
      o_WR_EN       <= wr_en_d;
      o_WR_DATA     <= wr_data_d;
      o_RD_EN       <= rd_en_d;
      o_ALU_EN      <= alu_en_d;
      o_ALU_FUN     <= alu_fun_d;
      o_CLK_GATE_EN <= gate_d;
      o_TX_DATA     <= tx_data_d;
      o_TX_VALID    <= tx_valid_d;
      o_CMD_DROP    <= drop_d;
      hi_q          <= hi_d;
      two_q         <= two_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rx_ok) begin
          case (i_RX_DATA)
            CMD_WR:     next_state = WR_ADDR;
            CMD_RD:     next_state = RD_ADDR;
            CMD_ALU_OP: next_state = OPA;
            CMD_ALU:    next_state = ALU_FUN;
            default:    next_state = IDLE;
          endcase
        end
      end
      WR_ADDR:  if (i_RX_VALID) next_state = rx_bad ? IDLE : WR_DATA;
      WR_DATA:  if (i_RX_VALID) next_state = IDLE;
      RD_ADDR:  if (i_RX_VALID) next_state = rx_bad ? IDLE : RD_WAIT;
      // Read data coincident with our own strobe is stale and ignored.
      RD_WAIT:  if (i_RD_VALID && !o_RD_EN) next_state = TX_LO;
      OPA:      if (i_RX_VALID) next_state = rx_bad ? IDLE : OPB;
      OPB:      if (i_RX_VALID) next_state = rx_bad ? IDLE : ALU_FUN;
      ALU_FUN:  if (i_RX_VALID) next_state = rx_bad ? IDLE : ALU_WAIT;
      ALU_WAIT: if (i_ALU_VALID) next_state = TX_LO;
      TX_LO:    if (!i_FIFO_FULL) next_state = two_q ? TX_HI : IDLE;
      TX_HI:    if (!i_FIFO_FULL) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    addr_d     = o_ADDR;
    wr_data_d  = o_WR_DATA;
    alu_fun_d  = o_ALU_FUN;
    gate_d     = o_CLK_GATE_EN;
    tx_data_d  = o_TX_DATA;
    hi_d       = hi_q;
    two_d      = two_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    tx_valid_d = 1'b0;
    drop_d     = rx_bad | (i_RX_VALID & busy);
    case (state)
      IDLE: begin
        if (rx_ok) begin
          case (i_RX_DATA)
            CMD_WR, CMD_RD, CMD_ALU_OP: ;
            CMD_ALU: gate_d = 1'b1;
            default: drop_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: if (rx_ok) addr_d = i_RX_DATA[ADDR-1:0];
      WR_DATA: if (rx_ok) begin
        wr_en_d   = 1'b1;
        wr_data_d = i_RX_DATA;
      end
      RD_ADDR: if (rx_ok) begin
        rd_en_d = 1'b1;
        addr_d  = i_RX_DATA[ADDR-1:0];
      end
      RD_WAIT: if (i_RD_VALID && !o_RD_EN) begin
        tx_data_d = i_RD_DATA;
        two_d     = 1'b0;
      end
      OPA: if (rx_ok) begin
        wr_en_d   = 1'b1;
        addr_d    = '0;
        wr_data_d = i_RX_DATA;
      end
      OPB: if (rx_ok) begin
        wr_en_d   = 1'b1;
        addr_d    = ADDR'(1);
        wr_data_d = i_RX_DATA;
        gate_d    = 1'b1;
      end
      ALU_FUN: begin
        if (rx_ok) begin
          alu_en_d  = 1'b1;
          alu_fun_d = i_RX_DATA[fun-1:0];
        end else if (rx_bad) begin
          gate_d = 1'b0;
        end
      end
      ALU_WAIT: if (i_ALU_VALID) begin
        tx_data_d = i_ALU_OUT[WIDTH_REG-1:0];
        hi_d      = i_ALU_OUT[2*WIDTH_REG-1:WIDTH_REG];
        two_d     = 1'b1;
        gate_d    = 1'b0;
      end
      TX_LO: if (!i_FIFO_FULL) tx_valid_d = 1'b1;
      // Low byte stays on o_TX_DATA until the high byte can actually be pushed.
      TX_HI: if (!i_FIFO_FULL) begin
        tx_valid_d = 1'b1;
        tx_data_d  = hi_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed self-checking bench for sys_ctrl: write, read, ALU paths, FIFO back-pressure,
// error/unknown-byte drops and mid-command reset.
module tb_sys_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_err;
  logic [3:0]  addr;
  logic        wr_en, rd_en, alu_en, gate, tx_valid, drop;
  logic [7:0]  wr_data, rd_data, tx_data;
  logic        rd_valid, alu_valid, full;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0, tx_cnt = 0, drop_cnt = 0;

  sys_ctrl #(.WIDTH_REG(8), .ADDR(4), .fun(4)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_RX_DATA(rx_data), .i_RX_VALID(rx_valid), .i_RX_ERR(rx_err),
    .o_ADDR(addr), .o_WR_EN(wr_en), .o_WR_DATA(wr_data), .o_RD_EN(rd_en),
    .i_RD_DATA(rd_data), .i_RD_VALID(rd_valid),
    .o_ALU_EN(alu_en), .o_ALU_FUN(alu_fun), .i_ALU_OUT(alu_out), .i_ALU_VALID(alu_valid),
    .o_CLK_GATE_EN(gate), .o_TX_DATA(tx_data), .o_TX_VALID(tx_valid),
    .i_FIFO_FULL(full), .o_CMD_DROP(drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en)    wr_cnt++;
    if (tx_valid) tx_cnt++;
    if (drop)     drop_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = e;
    tick();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b0, addr, wr_en, wr_data, rd_en, alu_en, alu_fun, gate, tx_data, tx_valid, drop};
  endfunction

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0;
    rd_data = '0; rd_valid = 1'b0; alu_out = '0; alu_valid = 1'b0; full = 1'b0;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 32'h0);
    rst = 1'b1;
    tick();

    // write: AA 04 55
    send(8'hAA, 1'b0);
    send(8'h04, 1'b0);
    send(8'h55, 1'b0);
    chk("wr_strobe", {wr_en, addr, wr_data}, {1'b1, 4'h4, 8'h55});
    tick();
    chk("wr_single", {wr_en, tx_valid}, 2'b00);

    // read: BB 04, stale return alongside o_RD_EN, real return two cycles later
    send(8'hBB, 1'b0);
    send(8'h04, 1'b0);
    chk("rd_strobe", {rd_en, addr}, {1'b1, 4'h4});
    rd_valid = 1'b1; rd_data = 8'h77;
    tick();
    rd_valid = 1'b0;
    chk("rd_single", {rd_en, tx_valid}, 2'b00);
    rd_valid = 1'b1; rd_data = 8'h55;
    tick();
    rd_valid = 1'b0;
    chk("rd_no_early_push", tx_valid, 1'b0);
    tick();
    chk("rd_push", {tx_valid, tx_data}, {1'b1, 8'h55});
    tick();
    chk("rd_push_once", tx_valid, 1'b0);

    // ALU with operands: CC 14 0A 02 -> 0x00C8
    send(8'hCC, 1'b0);
    send(8'h14, 1'b0);
    chk("opa_write", {wr_en, addr, wr_data}, {1'b1, 4'h0, 8'h14});
    send(8'h0A, 1'b0);
    chk("opb_write", {wr_en, addr, wr_data}, {1'b1, 4'h1, 8'h0A});
    chk("gate_before_alu", {gate, alu_en}, 2'b10);
    send(8'h02, 1'b0);
    chk("alu_start", {alu_en, alu_fun, gate}, {1'b1, 4'h2, 1'b1});
    alu_valid = 1'b1; alu_out = 16'h00C8;
    tick();
    alu_valid = 1'b0;
    chk("gate_drop", {gate, tx_valid, alu_en}, 3'b000);
    tick();
    chk("alu_push_lo", {tx_valid, tx_data}, {1'b1, 8'hC8});
    tick();
    chk("alu_push_hi", {tx_valid, tx_data}, {1'b1, 8'h00});
    tick();
    chk("alu_push_end", tx_valid, 1'b0);

    // ALU without operands: DD 01 -> 0x000A, FIFO full before the high byte
    send(8'hDD, 1'b0);
    chk("dd_gate", {gate, alu_en, wr_en}, 3'b100);
    send(8'h01, 1'b0);
    chk("dd_start", {alu_en, alu_fun, wr_en}, {1'b1, 4'h1, 1'b0});
    send(8'h33, 1'b0);
    chk("busy_drop", drop, 1'b1);
    alu_valid = 1'b1; alu_out = 16'h000A;
    tick();
    alu_valid = 1'b0;
    chk("dd_gate_drop", {gate, tx_valid}, 2'b00);
    tick();
    chk("dd_push_lo", {tx_valid, tx_data}, {1'b1, 8'h0A});
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_hold", {tx_valid, tx_data}, {1'b0, 8'h0A});
    end
    full = 1'b0;
    tick();
    chk("dd_push_hi", {tx_valid, tx_data}, {1'b1, 8'h00});
    tick();
    chk("dd_push_end", tx_valid, 1'b0);

    // unknown byte and error-aborted write
    send(8'h12, 1'b0);
    chk("unknown_drop", {drop, wr_en, rd_en, alu_en}, 4'b1000);
    send(8'hAA, 1'b0);
    send(8'h04, 1'b0);
    send(8'h55, 1'b1);
    chk("err_abort", {drop, wr_en}, 2'b10);
    send(8'hAA, 1'b0);
    send(8'h07, 1'b0);
    send(8'h66, 1'b0);
    chk("idle_after_err", {wr_en, addr, wr_data}, {1'b1, 4'h7, 8'h66});

    // reset mid-command
    send(8'hAA, 1'b0);
    send(8'h04, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midcmd_reset", all_outs(), 32'h0);
    send(8'h55, 1'b0);
    chk("post_reset_drop", {drop, wr_en}, 2'b10);
    tick();

    chk("total_writes", wr_cnt, 4);
    chk("total_pushes", tx_cnt, 5);
    chk("total_drops", drop_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
